adder58_shared_arbiter: RTL and testbench

//  Shares one customAdder58_21 instance (58-bit A + zero-extended 37-bit B -> 59-bit Sum)

---
 rtl/adder58_shared_arbiter.sv | 131 +++++++++++++
 tb/tb_adder58_shared_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder58_shared_arbiter.sv
// rtl/adder58_shared_arbiter.sv - two-requester round-robin arbiter sharing one 58+37 bit adder
module customAdder58_21 (
  input  logic [57:0] a,
  input  logic [36:0] b,
  output logic [58:0] sum
);

  // B is zero-extended by 21 bits; the carry out of bit 57 lands in bit 58
  always_comb begin
    sum = {1'b0, a} + {22'b0, b};
  end

endmodule

module adder58_shared_arbiter #(
  parameter int A_W   = 58,
  parameter int B_W   = 37,
  parameter bit RR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [A_W-1:0] req0_a,
  input  logic [B_W-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [A_W-1:0] req1_a,
  input  logic [B_W-1:0] req1_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [A_W:0]   res_sum,
  output logic           res_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  out_state_e     state_q;
  out_state_e     state_d;
  logic           prio_q;
  logic           prio_d;
  logic           slot_free;
  logic           grant_any;
  logic           grant_idx;
  logic [A_W-1:0] add_a;
  logic [B_W-1:0] add_b;
  logic [A_W:0]   add_sum;
  logic [A_W:0]   sum_q;
  logic           id_q;

  // Grant: a slot opens when empty or when the held result drains this cycle.
  // Gated by rst_n so no pair is ever accepted while reset is asserted.
  always_comb begin
    slot_free = (state_q == EMPTY) || res_ready;
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (slot_free && rst_n) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_idx = RR_EN ? prio_q : 1'b0;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~grant_idx;
  assign req1_ready = grant_any &  grant_idx;

  // Operand mux into the single shared adder
  always_comb begin
    add_a = grant_idx ? req1_a : req0_a;
    add_b = grant_idx ? req1_b : req0_b;
  end

  customAdder58_21 u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  // Output-stage next state plus priority pointer update
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      EMPTY: begin
        if (grant_any) state_d = FULL;
      end
      FULL: begin
        if (res_ready && !grant_any) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (grant_any) prio_d = RR_EN ? ~grant_idx : 1'b0;
  end

  // State and priority registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Result register loads only on a grant, so a stalled result holds steady
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      id_q  <= 1'b0;
    end else if (grant_any) begin
      sum_q <= add_sum;
      id_q  <= grant_idx;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_adder58_shared_arbiter.sv
// tb/tb_adder58_shared_arbiter.sv - randomized and directed bench for adder58_shared_arbiter
module tb_adder58_shared_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v0 [2];
  logic        v1 [2];
  logic        rr [2];
  logic [57:0] a0 [2];
  logic [57:0] a1 [2];
  logic [36:0] b0 [2];
  logic [36:0] b1 [2];
  logic        rd0 [2];
  logic        rd1 [2];
  logic        rv  [2];
  logic        rid [2];
  logic [58:0] rs  [2];

  int checks = 0;
  int errors = 0;

  // Requester stimulus state: instance k, requester i
  bit          pend [2][2];
  logic [57:0] pa   [2][2];
  logic [36:0] pb   [2][2];
  int          prob [2][2];

  // Reference model: a one-entry result slot per instance
  bit          m_full [2];
  bit          m_id   [2];
  bit          m_prio [2];
  logic [58:0] m_sum  [2];

  // Values observed in the most recent step
  bit          o_rd0 [2];
  bit          o_rd1 [2];
  bit          o_rv  [2];
  bit          o_rid [2];
  logic [58:0] o_sum [2];

  adder58_shared_arbiter #(.A_W(58), .B_W(37), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[0]), .req0_ready(rd0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req1_valid(v1[0]), .req1_ready(rd1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .res_valid(rv[0]), .res_ready(rr[0]), .res_sum(rs[0]), .res_id(rid[0])
  );

  adder58_shared_arbiter #(.A_W(58), .B_W(37), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[1]), .req0_ready(rd0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req1_valid(v1[1]), .req1_ready(rd1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .res_valid(rv[1]), .res_ready(rr[1]), .res_sum(rs[1]), .res_id(rid[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_models();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 1'b0;
      m_id[k]   = 1'b0;
      m_prio[k] = 1'b0;
      m_sum[k]  = '0;
    end
  endtask

  task automatic drive_ports();
    for (int k = 0; k < 2; k++) begin
      v0[k] = pend[k][0]; a0[k] = pa[k][0]; b0[k] = pb[k][0];
      v1[k] = pend[k][1]; a1[k] = pa[k][1]; b1[k] = pb[k][1];
    end
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge
  task automatic step();
    bit g_any;
    bit g_idx;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++)
        if (!pend[k][i] && ($urandom_range(99) < prob[k][i])) begin
          pend[k][i] = 1'b1;
          if ($urandom_range(7) == 0) begin
            pa[k][i] = '1;
            pb[k][i] = '1;
          end else begin
            pa[k][i] = 58'({$urandom, $urandom});
            pb[k][i] = 37'({$urandom, $urandom});
          end
        end
    drive_ports();
    #1;
    for (int k = 0; k < 2; k++) begin
      o_rd0[k] = rd0[k]; o_rd1[k] = rd1[k]; o_rv[k] = rv[k];
      o_rid[k] = rid[k]; o_sum[k] = rs[k];
      g_any = 1'b0;
      g_idx = 1'b0;
      if (!m_full[k] || rr[k]) begin
        if (pend[k][0] && pend[k][1]) begin
          g_any = 1'b1;
          g_idx = (k == 0) ? m_prio[k] : 1'b0;
        end else if (pend[k][0]) begin
          g_any = 1'b1;
        end else if (pend[k][1]) begin
          g_any = 1'b1;
          g_idx = 1'b1;
        end
      end
      check($sformatf("i%0d_rdy0", k), 64'(o_rd0[k]), 64'(g_any && !g_idx));
      check($sformatf("i%0d_rdy1", k), 64'(o_rd1[k]), 64'(g_any && g_idx));
      check($sformatf("i%0d_valid", k), 64'(o_rv[k]), 64'(m_full[k]));
      if (m_full[k]) begin
        check($sformatf("i%0d_sum", k), 64'(o_sum[k]), 64'(m_sum[k]));
        check($sformatf("i%0d_id", k), 64'(o_rid[k]), 64'(m_id[k]));
      end
      if (g_any) begin
        m_full[k] = 1'b1;
        m_sum[k]  = 59'(pa[k][g_idx]) + 59'(pb[k][g_idx]);
        m_id[k]   = g_idx;
        m_prio[k] = !g_idx;
        pend[k][g_idx] = 1'b0;
      end else if (rr[k]) begin
        m_full[k] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++) begin
        pend[k][i] = 1'b0;
        prob[k][i] = 0;
      end
  endtask

  task automatic do_reset();
    clear_stim();
    drive_ports();
    rst_n = 1'b0;
    reset_models();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [58:0] held;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_stim();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++) begin
        pa[k][i] = '0;
        pb[k][i] = '0;
      end
    rr[0] = 1'b0; rr[1] = 1'b0;
    reset_models();
    pend[0][0] = 1'b1;
    pend[1][1] = 1'b1;
    drive_ports();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 64'(rv[0]), 64'd0);
    check("rst_sum", 64'(rs[0]), 64'd0);
    check("rst_id", 64'(rid[0]), 64'd0);
    check("rst_rdy0", 64'(rd0[0]), 64'd0);
    check("rst_rdy1_fp", 64'(rd1[1]), 64'd0);
    clear_stim();
    rst_n = 1'b1;

    // Single small add
    pend[0][0] = 1'b1; pa[0][0] = 58'h5; pb[0][0] = 37'h3;
    rr[0] = 1'b1; rr[1] = 1'b1;
    step();
    check("single_rdy", 64'(o_rd0[0]), 64'd1);
    step();
    check("single_valid", 64'(o_rv[0]), 64'd1);
    check("single_sum", 64'(o_sum[0]), 64'h8);
    check("single_id", 64'(o_rid[0]), 64'd0);

    // Maximum operands through requester 1
    pend[0][1] = 1'b1; pa[0][1] = 58'h3FF_FFFF_FFFF_FFFF; pb[0][1] = 37'h1F_FFFF_FFFF;
    step();
    step();
    check("max_sum", 64'(o_sum[0]), 64'h400_001F_FFFF_FFFE);
    check("max_id", 64'(o_rid[0]), 64'd1);

    // Async reset while a result is held
    pend[0][0] = 1'b1; pa[0][0] = 58'h123; pb[0][0] = 37'h45;
    rr[0] = 1'b0;
    step();
    pend[0][0] = 1'b1;
    drive_ports();
    #1;
    check("pre_rst_valid", 64'(rv[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(rv[0]), 64'd0);
    check("async_sum", 64'(rs[0]), 64'd0);
    check("async_rdy0", 64'(rd0[0]), 64'd0);
    reset_models();
    rst_n = 1'b1;
    step();
    check("post_rst_rdy0", 64'(o_rd0[0]), 64'd1);
    step();
    check("post_rst_valid", 64'(o_rv[0]), 64'd1);

    // Round-robin contention
    do_reset();
    rr[0] = 1'b1; rr[1] = 1'b1;
    prob[0][0] = 100; prob[0][1] = 100;
    for (int s = 0; s < 7; s++) begin
      step();
      if (s < 6) check("rr_one_ready", 64'(o_rd0[0] ^ o_rd1[0]), 64'd1);
      if (s >= 1) begin
        check("rr_valid", 64'(o_rv[0]), 64'd1);
        check("rr_id", 64'(o_rid[0]), 64'((s - 1) % 2));
      end
    end

    // Backpressure while both requesters keep asking
    rr[0] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      if (s == 0) held = o_sum[0];
      else check("bp_hold_sum", 64'(o_sum[0]), 64'(held));
      check("bp_no_ready", 64'(o_rd0[0] | o_rd1[0]), 64'd0);
      check("bp_valid", 64'(o_rv[0]), 64'd1);
    end
    rr[0] = 1'b1;
    step();
    check("bp_refill_ready", 64'(o_rd0[0] | o_rd1[0]), 64'd1);
    step();
    check("bp_no_bubble", 64'(o_rv[0]), 64'd1);

    // Fixed priority instance
    do_reset();
    rr[0] = 1'b1; rr[1] = 1'b1;
    prob[1][0] = 100; prob[1][1] = 100;
    for (int s = 0; s < 4; s++) begin
      step();
      if (s < 3) check("fp_rdy1_blocked", 64'(o_rd1[1]), 64'd0);
      if (s >= 1) check("fp_id", 64'(o_rid[1]), 64'd0);
    end
    prob[1][0] = 0;
    pend[1][0] = 1'b0;
    step();
    check("fp_req1_wins", 64'(o_rd1[1]), 64'd1);
    step();
    check("fp_req1_id", 64'(o_rid[1]), 64'd1);

    // Randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < 2; i++)
            prob[k][i] = $urandom_range(100, 10);
      rr[0] = ($urandom_range(3) != 0);
      rr[1] = ($urandom_range(1) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
